// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared MIPS core constants for the register-destination scoreboard.
package mips_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/reg_dest_scoreboard_sb_pending_counter.sv
// One per-register pending-write counter: up on issue, down on writeback,
// flags saturation and writebacks that arrive with nothing pending.
module sb_pending_counter
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_req,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             underflow
);
  logic [CNT_W-1:0] cnt_q;
  logic             inc_ok;
  logic             dec_ok;

  assign sat       = (cnt_q == '1);
  assign inc_ok    = inc & ~sat;
  assign dec_ok    = dec_req & (cnt_q != '0);
  assign underflow = dec_req & (cnt_q == '0);
  assign cnt       = cnt_q;

  // Simultaneous inc and dec cancel; a write retires as another is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/reg_dest_scoreboard.sv
// Per-register pending-write scoreboard between decode and writeback.
// Optional macro SCOREBOARD_WB_BYPASS_EN: same-cycle last writeback clears busy.
module reg_dest_scoreboard
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  output logic              wb_underflow
);
  // Issue handshake: a transfer happens on a rising edge where issue_valid
  // and issue_ready are both high; issue_ready depends only on issue_dest
  // and the registered counters, never on issue_valid.
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] sat;
  logic [NUM_REGS-1:0] uf_evt;
  logic                issue_acc;
  logic                underflow_q;

  assign cnt[0]    = '0;
  assign sat[0]    = 1'b0;
  assign uf_evt[0] = 1'b0;

  assign issue_ready = (issue_dest == REG_ZERO) | ~sat[issue_dest];
  assign issue_acc   = issue_valid & issue_ready;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_pending_counter u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (issue_acc && (issue_dest == ADDR_W'(r))),
      .dec_req   (wb_valid && (wb_dest == ADDR_W'(r))),
      .cnt       (cnt[r]),
      .sat       (sat[r]),
      .underflow (uf_evt[r])
    );
  end

  always_comb begin
    rs_busy = (rs_addr != REG_ZERO) && (cnt[rs_addr] != '0);
    rt_busy = (rt_addr != REG_ZERO) && (cnt[rt_addr] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The register file writes before it reads, so the last owed write is visible now.
    if (wb_valid && (wb_dest == rs_addr) && (cnt[rs_addr] == CNT_W'(1))) rs_busy = 1'b0;
    if (wb_valid && (wb_dest == rt_addr) && (cnt[rt_addr] == CNT_W'(1))) rt_busy = 1'b0;
`endif
  end

  assign stall = rs_busy | rt_busy | (issue_valid & ~issue_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (|uf_evt) begin
      underflow_q <= 1'b1;
    end
  end

  assign wb_underflow = underflow_q;
endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Self-checking bench for reg_dest_scoreboard; honours SCOREBOARD_WB_BYPASS_EN.
module tb_reg_dest_scoreboard;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, wb_valid;
  logic [4:0] issue_dest, wb_dest, rs_addr, rt_addr;
  logic       issue_ready, rs_busy, rt_busy, stall, wb_underflow;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_dest_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall),
    .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  // Expected vector order: {issue_ready, rs_busy, rt_busy, stall}
  task automatic drive(input logic iv, input logic [4:0] id, input logic wv,
                       input logic [4:0] wd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [3:0] exp);
    issue_valid = iv; issue_dest = id; wb_valid = wv; wb_dest = wd;
    rs_addr = rs; rt_addr = rt;
    exp_q.push_back(exp);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b0, 5'd0, 5'd3, 5'd4, 4'b1000);
    tick(); tick();
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL reset_in got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    drive(1'b0, 5'd5, 1'b0, 5'd0, 5'd3, 5'd4, 4'b1000);
    rst_n = 1'b1;
    #1;
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL reset_out got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    total++;
    if (wb_underflow !== 1'b0) begin bad++; $display("FAIL reset_uf got=%b exp=0", wb_underflow); end
  endtask

  task automatic test_issue_busy();
    tick();
    drive(1'b1, 5'd8, 1'b0, 5'd0, 5'd8, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL issue_same_cycle got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd8, 1'b0, 5'd0, 5'd8, 5'd0, 4'b1101);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL issue_next_cycle got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick(); tick();
    drive(1'b0, 5'd0, 1'b1, 5'd8, 5'd8, 5'd0, BYP ? 4'b1000 : 4'b1101);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL wb_same_cycle got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd8, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL wb_next_cycle got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 1'b0, 5'd0, 5'd3, 5'd4, 4'b1000);
      e = exp_q.pop_front(); total++;
      if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL sat_fill%0d got=%b exp=%b", i, {issue_ready, rs_busy, rt_busy, stall}, e); end
      tick();
    end
    drive(1'b1, 5'd9, 1'b0, 5'd0, 5'd3, 5'd4, 4'b0001);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL sat_full got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd9, 1'b0, 5'd0, 5'd3, 5'd9, 4'b0011);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL sat_hold got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    drive(1'b0, 5'd9, 1'b1, 5'd9, 5'd3, 5'd4, 4'b0000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL sat_wb_cycle got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd9, 1'b0, 5'd0, 5'd3, 5'd9, 4'b1011);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL sat_release got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
  endtask

  task automatic test_simul();
    tick();
    drive(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL simul_first got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd10, 5'd10, 5'd0, BYP ? 4'b1000 : 4'b1101);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL simul_both got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd10, 1'b0, 5'd0, 5'd10, 5'd0, 4'b1101);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL simul_held got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    drive(1'b0, 5'd0, 1'b1, 5'd10, 5'd0, 5'd0, 4'b1000);
    void'(exp_q.pop_front());
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd10, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL simul_drained got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    total++;
    if (wb_underflow !== 1'b0) begin bad++; $display("FAIL simul_uf got=%b exp=0", wb_underflow); end
  endtask

  task automatic test_zero();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL zero_issue got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL zero_after got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    total++;
    if (wb_underflow !== 1'b0) begin bad++; $display("FAIL zero_uf got=%b exp=0", wb_underflow); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 5'd0, 1'b1, 5'd12, 5'd12, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL uf_wb got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    total++;
    if (wb_underflow !== 1'b0) begin bad++; $display("FAIL uf_before got=%b exp=0", wb_underflow); end
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd12, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL uf_cnt_zero got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    total++;
    if (wb_underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", wb_underflow); end
    repeat (3) tick();
    total++;
    if (wb_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", wb_underflow); end
  endtask

  task automatic test_back_to_back();
    int m [8];
    logic uf_m;
    logic iv, wv, rdy, rsb, rtb, inc, dec;
    logic [4:0] id, wd, rs, rt;
    for (int r = 0; r < 8; r++) m[r] = 0;
    uf_m = 1'b1;
    for (int n = 0; n < 80; n++) begin
      iv = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 2) == 0);
      id = 5'($urandom_range(1, 7));
      wd = 5'($urandom_range(1, 7));
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rdy = (m[id] != 3);
      rsb = (rs != 0) && (m[rs] != 0) && !(BYP && wv && (wd == rs) && (m[rs] == 1));
      rtb = (rt != 0) && (m[rt] != 0) && !(BYP && wv && (wd == rt) && (m[rt] == 1));
      drive(iv, id, wv, wd, rs, rt, {rdy, rsb, rtb, rsb | rtb | (iv & ~rdy)});
      e = exp_q.pop_front(); total++;
      if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL rand%0d got=%b exp=%b", n, {issue_ready, rs_busy, rt_busy, stall}, e); end
      inc = iv && rdy;
      dec = wv && (m[wd] != 0);
      if (wv && (m[wd] == 0)) uf_m = 1'b1;
      if (!(inc && dec && (id == wd))) begin
        if (inc) m[id] = m[id] + 1;
        if (dec) m[wd] = m[wd] - 1;
      end
      tick();
      total++;
      if (wb_underflow !== uf_m) begin bad++; $display("FAIL rand_uf%0d got=%b exp=%b", n, wb_underflow, uf_m); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd9, 4'b1111);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL mid_before got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    rst_n = 1'b0;
    drive(1'b0, 5'd9, 1'b0, 5'd0, 5'd9, 5'd9, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL mid_async got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    total++;
    if (wb_underflow !== 1'b0) begin bad++; $display("FAIL mid_uf_clear got=%b exp=0", wb_underflow); end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd0, 4'b1000);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL mid_reissue got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 5'd0, 4'b1101);
    e = exp_q.pop_front(); total++;
    if ({issue_ready, rs_busy, rt_busy, stall} !== e) begin bad++; $display("FAIL mid_busy_again got=%b exp=%b", {issue_ready, rs_busy, rt_busy, stall}, e); end
  endtask

  initial begin
    test_reset();
    test_issue_busy();
    test_saturate();
    test_simul();
    test_zero();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
